// File: rtl/logIP_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default bit period.
package logIP_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   // 100 MHz system clock, 115200 baud
   localparam int unsigned CLK_PER_BIT_DEF = 868;

endpackage

// File: rtl/syncro.sv
// Two-flop synchronizer for asynchronous inputs; output lags input by 2 clocks.
// Reset value is parameterizable; it defaults to all ones so an idle-high line stays quiet.
module syncro #(
   parameter int              WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; stb_o/ferr_o pulse 1 clk after the stop-bit sample (+2 clk synchronizer).
// No backpressure: each byte is presented once on data_o; UART_RX_MAJORITY_EN enables 3-sample voting.
module uart_rx
   import logIP_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF
) (
   input  logic       clk_i,
   input  logic       rst_in,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       stb_o,
   output logic       ferr_o
);

   localparam int CW = $clog2(CLK_PER_BIT);
   // With voting, the decision lands one cycle after mid-bit so the window is centred.
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned START_PT = CLK_PER_BIT / 2 + 1;
`else
   localparam int unsigned START_PT = CLK_PER_BIT / 2;
`endif
   localparam int unsigned BIT_PT = CLK_PER_BIT - 1;

   logic          rxs;
   logic          smp;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          tick, shift_en, stb_nxt, ferr_nxt;

   syncro #(.WIDTH(1)) u_sync (
      .clk_i  (clk_i),
      .rst_in (rst_in),
      .d      (rx_i),
      .q      (rxs)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) hist <= 2'b11;
      else         hist <= {hist[0], rxs};
   end

   assign smp = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
   assign smp = rxs;
`endif

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tick      = 1'b0;
      shift_en  = 1'b0;
      stb_nxt   = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) state_nxt = START;
         end
         START: begin
            tick = (cnt == CW'(START_PT));
            if (tick) state_nxt = smp ? IDLE : DATA;
         end
         DATA: begin
            tick = (cnt == CW'(BIT_PT));
            if (tick) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            tick = (cnt == CW'(BIT_PT));
            if (tick) begin
               if (smp) begin
                  stb_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         cnt     <= '0;
         bit_cnt <= 3'd0;
         shreg   <= 8'h00;
         data_o  <= 8'h00;
         stb_o   <= 1'b0;
         ferr_o  <= 1'b0;
      end else begin
         stb_o  <= stb_nxt;
         ferr_o <= ferr_nxt;
         // Baud counter restarts at every sample so the next sample is one bit period later.
         if (state == IDLE || state == WAIT_HIGH || tick) cnt <= '0;
         else                                              cnt <= cnt + 1'b1;
         if (state != DATA)  bit_cnt <= 3'd0;
         else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) shreg  <= {smp, shreg[7:1]};
         if (stb_nxt)  data_o <= shreg;
      end
   end

endmodule
